// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM encodings and source indices.
// Also provides a helper that decodes a register offset into a one-hot select.
package irq_controller_pkg;

  localparam logic [3:0] IRQ_PEND   = 4'h0;
  localparam logic [3:0] IRQ_ENABLE = 4'h4;
  localparam logic [3:0] IRQ_VECTOR = 4'h8;
  localparam logic [3:0] IRQ_EOI    = 4'hC;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam int IRQ_TIMER   = 0;
  localparam int IRQ_UART_RX = 1;
  localparam int IRQ_UART_TX = 2;

  typedef struct packed {
    logic pend;
    logic enable;
    logic vector;
    logic eoi;
  } reg_sel_t;

  function automatic reg_sel_t reg_decode(input logic [3:0] off);
    reg_sel_t s;
    s = '0;
    case (off)
      IRQ_PEND:   s.pend   = 1'b1;
      IRQ_ENABLE: s.enable = 1'b1;
      IRQ_VECTOR: s.vector = 1'b1;
      IRQ_EOI:    s.eoi    = 1'b1;
      default:    ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Peripheral bus seen by the interrupt controller: MEM-stage strobes, address, write data, read data.
// rdata is combinational from the slave and is zero unless the slave is being read.
interface irq_bus_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, wr, addr, wdata, input rdata);
  modport slave  (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/irq_controller_prio_enc.sv
// Lowest-index-wins priority encoder over the active request vector; purely combinational.
// No flow control: sel_vld simply reports whether any request is active.
module irq_prio_enc #(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0] req,
  output logic             sel_vld,
  output logic [2:0]       sel_id
);

  always_comb begin
    sel_vld = |req;
    sel_id  = '0;
    // Walk from the top down so the lowest set index is the last one written.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) sel_id = 3'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-detecting, prioritising interrupt controller with a memory-mapped PEND/ENABLE/VECTOR/EOI block.
// Source edge to irqout is two cycles; one request at a time, held off while PC_31 is set.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int          N_SRC     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0030
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  irq_bus_if.slave         bus,
  input  logic             PC_31,
  output logic             irqout,
  output logic [2:0]       cur_id
);

  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] enable;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] cur_mask;
  logic [N_SRC-1:0] w1c_mask;
  logic [N_SRC-1:0] ack_mask;
  logic [1:0]       state;
  logic             hit;
  logic             in_service;
  logic             eoi_wr;
  logic             sel_vld;
  logic [2:0]       sel_id;
  reg_sel_t         sel;
  logic             unused_bus;

  assign hit        = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign sel        = hit ? reg_decode({bus.addr[3:2], 2'b00}) : '0;
  assign rise       = src & ~src_q;
  assign in_service = (state == ST_SERVICE);
  assign eoi_wr     = bus.wr & sel.eoi;
  assign w1c_mask   = (bus.wr & sel.pend) ? bus.wdata[N_SRC-1:0] : '0;
  assign ack_mask   = ((state == ST_REQ) && PC_31) ? cur_mask : '0;
  assign unused_bus = ^{bus.addr[1:0], bus.wdata[31:N_SRC]};

  always_comb begin
    cur_mask = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cur_mask[i] = (cur_id == 3'(i));
    end
  end

  irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
    .req     (pending & enable),
    .sel_vld (sel_vld),
    .sel_id  (sel_id)
  );

  always_ff @(posedge sysclk) begin
    if (reset) begin
      src_q   <= '0;
      pending <= '0;
      enable  <= '0;
      state   <= ST_IDLE;
      irqout  <= 1'b0;
      cur_id  <= '0;
    end else begin
      src_q   <= src;
      // A fresh edge beats both a software clear and the acknowledge clear.
      pending <= (pending & ~w1c_mask & ~ack_mask) | rise;
      if (bus.wr && sel.enable) enable <= bus.wdata[N_SRC-1:0];

      case (state)
        ST_IDLE: begin
          if (sel_vld && !PC_31) begin
            state  <= ST_REQ;
            cur_id <= sel_id;
            irqout <= 1'b1;
          end
        end
        ST_REQ: begin
          if (PC_31) begin
            state  <= ST_SERVICE;
            irqout <= 1'b0;
          end else if (!(|(pending & enable & cur_mask))) begin
            state  <= ST_IDLE;
            irqout <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (eoi_wr) state <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          irqout <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.rd) begin
      if (sel.pend)   bus.rdata[N_SRC-1:0] = pending;
      if (sel.enable) bus.rdata[N_SRC-1:0] = enable;
      if (sel.vector) bus.rdata = {in_service, 28'b0, cur_id};
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed sequences, an address-decode vector table and a randomized run against a behavioural model.
module tb_irq_controller;
  import irq_controller_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0030;

  logic       sysclk = 1'b0;
  logic       reset;
  logic [3:0] src;
  logic       pc_31;
  logic       irqout;
  logic [2:0] cur_id;

  int total = 0;
  int bad   = 0;

  irq_bus_if bus ();

  irq_controller #(.N_SRC(4), .BASE_ADDR(BASE)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .src    (src),
    .bus    (bus),
    .PC_31  (pc_31),
    .irqout (irqout),
    .cur_id (cur_id)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic idle_bus();
    bus.rd    = 1'b0;
    bus.wr    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
  endtask

  task automatic wr_reg(input logic [3:0] off, input logic [31:0] d);
    bus.wr    = 1'b1;
    bus.addr  = BASE | {28'b0, off};
    bus.wdata = d;
    tick();
    idle_bus();
  endtask

  task automatic rd_reg(input logic [3:0] off, output logic [31:0] d);
    bus.rd   = 1'b1;
    bus.addr = BASE | {28'b0, off};
    #1;
    d = bus.rdata;
    idle_bus();
  endtask

  task automatic pulse_src(input logic [3:0] s);
    src = s;
    tick();
    src = 4'h0;
  endtask

  // Behavioural model state
  logic [3:0] m_pend, m_en, m_srcq;
  logic [2:0] m_id;
  bit         m_req, m_svc;

  initial begin
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic [3:0]  off;
    logic [3:0]  nxt_pend;
    logic [3:0]  woff;
    bit          hit_w, is_rd, found;
    int          op;

    tbl[0] = '{1'b1, 32'h4000_0034, 32'h0000_0005};
    tbl[1] = '{1'b1, 32'h4000_0037, 32'h0000_0005};
    tbl[2] = '{1'b0, 32'h4000_0034, 32'h0000_0000};
    tbl[3] = '{1'b1, 32'h4000_0030, 32'h0000_0000};
    tbl[4] = '{1'b1, 32'h4000_0038, 32'h0000_0000};
    tbl[5] = '{1'b1, 32'h4000_003C, 32'h0000_0000};
    tbl[6] = '{1'b1, 32'h4000_0044, 32'h0000_0000};
    tbl[7] = '{1'b1, 32'h4000_0024, 32'h0000_0000};
    tbl[8] = '{1'b1, 32'hC000_0034, 32'h0000_0000};
    tbl[9] = '{1'b1, 32'h4000_1034, 32'h0000_0000};

    idle_bus();
    reset = 1'b1;
    src   = 4'h0;
    pc_31 = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // 1: reset state and basic two-cycle latency
    chk("rst_irqout", {31'b0, irqout}, 32'd0);
    chk("rst_cur_id", {29'b0, cur_id}, 32'd0);
    rd_reg(IRQ_PEND, d);   chk("rst_pend", d, 32'h0);
    rd_reg(IRQ_ENABLE, d); chk("rst_enable", d, 32'h0);
    rd_reg(IRQ_VECTOR, d); chk("rst_vector", d, 32'h0);
    wr_reg(IRQ_ENABLE, 32'hF);
    pulse_src(4'(1 << IRQ_UART_TX));
    rd_reg(IRQ_PEND, d);   chk("t1_pend", d, 32'h4);
    chk("t1_irq_early", {31'b0, irqout}, 32'd0);
    tick();
    chk("t1_irqout", {31'b0, irqout}, 32'd1);
    chk("t1_cur_id", {29'b0, cur_id}, 32'd2);
    pc_31 = 1'b1;
    tick();
    chk("t1_ack_irq", {31'b0, irqout}, 32'd0);
    rd_reg(IRQ_PEND, d);   chk("t1_ack_pend", d, 32'h0);
    pc_31 = 1'b0;
    wr_reg(IRQ_EOI, 32'h0);
    tick();

    // 2: simultaneous sources, priority then second request after EOI
    pulse_src(4'b1010);
    tick();
    chk("t2_irqout", {31'b0, irqout}, 32'd1);
    chk("t2_cur_id", {29'b0, cur_id}, 32'd1);
    pc_31 = 1'b1;
    tick();
    pc_31 = 1'b0;
    tick();
    rd_reg(IRQ_VECTOR, d); chk("t2_svc_hold", d, 32'h8000_0001);
    chk("t2_svc_irq", {31'b0, irqout}, 32'd0);
    wr_reg(IRQ_EOI, 32'h0);
    chk("t2_eoi_gap", {31'b0, irqout}, 32'd0);
    tick();
    chk("t2_irqout2", {31'b0, irqout}, 32'd1);
    chk("t2_cur_id2", {29'b0, cur_id}, 32'd3);
    pc_31 = 1'b1;
    tick();
    pc_31 = 1'b0;
    wr_reg(IRQ_EOI, 32'h0);
    tick();

    // 3: masked source stays pending until enabled
    wr_reg(IRQ_ENABLE, 32'h0);
    pulse_src(4'b0001);
    tick();
    rd_reg(IRQ_PEND, d);   chk("t3_pend", d, 32'h1);
    chk("t3_masked", {31'b0, irqout}, 32'd0);
    wr_reg(IRQ_ENABLE, 32'h1);
    chk("t3_en_gap", {31'b0, irqout}, 32'd0);
    tick();
    chk("t3_irqout", {31'b0, irqout}, 32'd1);
    chk("t3_cur_id", {29'b0, cur_id}, 32'd0);

    // 4: cancel from REQ by W1C, then PC_31 wins over the same clear
    wr_reg(IRQ_PEND, 32'h1);
    tick();
    chk("t4_cancel0", {31'b0, irqout}, 32'd0);
    wr_reg(IRQ_ENABLE, 32'hF);
    pulse_src(4'b0100);
    tick();
    chk("t4_req2", {29'b0, cur_id}, 32'd2);
    wr_reg(IRQ_PEND, 32'h4);
    tick();
    chk("t4_cancel_irq", {31'b0, irqout}, 32'd0);
    rd_reg(IRQ_VECTOR, d); chk("t4_cancel_vec", d, 32'h0000_0002);
    pulse_src(4'b0100);
    tick();
    chk("t4_req2b", {31'b0, irqout}, 32'd1);
    pc_31 = 1'b1;
    wr_reg(IRQ_PEND, 32'h4);
    chk("t4_svc_irq", {31'b0, irqout}, 32'd0);
    rd_reg(IRQ_VECTOR, d); chk("t4_svc_vec", d, 32'h8000_0002);
    pc_31 = 1'b0;

    // 5: edges latch during SERVICE, EOI re-arms
    pulse_src(4'b0001);
    tick();
    rd_reg(IRQ_PEND, d);   chk("t5_pend", d, 32'h1);
    chk("t5_no_nest", {31'b0, irqout}, 32'd0);
    rd_reg(IRQ_VECTOR, d); chk("t5_vec", d, 32'h8000_0002);
    wr_reg(IRQ_EOI, 32'h0);
    chk("t5_eoi_gap", {31'b0, irqout}, 32'd0);
    tick();
    chk("t5_irqout", {31'b0, irqout}, 32'd1);
    chk("t5_cur_id", {29'b0, cur_id}, 32'd0);

    // 6: reset in REQ and in SERVICE
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_req_irq", {31'b0, irqout}, 32'd0);
    rd_reg(IRQ_PEND, d);   chk("t6_req_pend", d, 32'h0);
    rd_reg(IRQ_ENABLE, d); chk("t6_req_en", d, 32'h0);
    wr_reg(IRQ_ENABLE, 32'hF);
    pulse_src(4'b1000);
    tick();
    pc_31 = 1'b1;
    tick();
    rd_reg(IRQ_VECTOR, d); chk("t6_in_svc", d, 32'h8000_0003);
    pulse_src(4'b0010);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pc_31 = 1'b0;
    chk("t6_svc_irq", {31'b0, irqout}, 32'd0);
    rd_reg(IRQ_VECTOR, d); chk("t6_svc_vec", d, 32'h0);
    rd_reg(IRQ_PEND, d);   chk("t6_svc_pend", d, 32'h0);
    rd_reg(IRQ_ENABLE, d); chk("t6_svc_en", d, 32'h0);

    // Address decode table
    wr_reg(IRQ_ENABLE, 32'h5);
    for (int i = 0; i < 10; i++) begin
      bus.rd   = tbl[i].rd;
      bus.addr = tbl[i].addr;
      #1;
      chk($sformatf("tbl%0d", i), bus.rdata, tbl[i].exp);
      idle_bus();
    end

    // Randomized run against the behavioural model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_pend = '0; m_en = '0; m_srcq = '0; m_id = '0; m_req = 0; m_svc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle_bus();
      is_rd = 0;
      src = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) pc_31 = ~pc_31;
      op  = $urandom_range(0, 9);
      off = 4'($urandom_range(0, 3) << 2);
      bus.addr = BASE | {28'b0, off} | 32'($urandom_range(0, 3));
      if (op == 0) begin
        bus.wr = 1'b1; bus.addr = BASE | {28'b0, IRQ_ENABLE}; bus.wdata = $urandom;
      end else if (op == 1) begin
        bus.wr = 1'b1; bus.addr = BASE | {28'b0, IRQ_PEND}; bus.wdata = $urandom;
      end else if (op == 2 || op == 3) begin
        bus.wr = 1'b1; bus.addr = BASE | {28'b0, IRQ_EOI}; bus.wdata = $urandom;
      end else if (op <= 6) begin
        bus.rd = 1'b1; is_rd = 1;
        if ($urandom_range(0, 4) == 0) bus.addr = bus.addr + 32'h10;
      end
      #1;
      if (is_rd) begin
        exp_rd = '0;
        if (bus.addr[31:4] == BASE[31:4]) begin
          if (off == IRQ_PEND)   exp_rd = {28'b0, m_pend};
          if (off == IRQ_ENABLE) exp_rd = {28'b0, m_en};
          if (off == IRQ_VECTOR) exp_rd = {m_svc, 28'b0, m_id};
        end
        chk("rand_rd", bus.rdata, exp_rd);
      end

      hit_w = bus.wr && (bus.addr[31:4] == BASE[31:4]);
      woff  = {bus.addr[3:2], 2'b00};
      nxt_pend = m_pend;
      for (int i = 0; i < 4; i++) begin
        if (hit_w && woff == IRQ_PEND && bus.wdata[i]) nxt_pend[i] = 1'b0;
        if (m_req && pc_31 && m_id == 3'(i)) nxt_pend[i] = 1'b0;
        if (src[i] && !m_srcq[i]) nxt_pend[i] = 1'b1;
      end
      if (m_svc) begin
        if (hit_w && woff == IRQ_EOI) m_svc = 0;
      end else if (m_req) begin
        if (pc_31) begin
          m_req = 0; m_svc = 1;
        end else if (!(m_pend[m_id[1:0]] && m_en[m_id[1:0]])) begin
          m_req = 0;
        end
      end else if (!pc_31) begin
        found = 0;
        for (int i = 0; i < 4; i++) begin
          if (!found && m_pend[i] && m_en[i]) begin
            found = 1; m_req = 1; m_id = 3'(i);
          end
        end
      end
      m_pend = nxt_pend;
      if (hit_w && woff == IRQ_ENABLE) m_en = bus.wdata[3:0];
      m_srcq = src;

      tick();
      chk("rand_irqout", {31'b0, irqout}, {31'b0, m_req});
      chk("rand_cur_id", {29'b0, cur_id}, {29'b0, m_id});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
